// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
//
// Round-robin arbiter and sequencer that shares one WIDTH x WIDTH shift-add
// multiplier (controller + datapath) between two requesters. It captures the
// winner's operands, pulses the multiplier start, waits for its done, returns
// the registered product to the owner and frees the resource.
//
// Optional feature: define MULT_ARB_TIMEOUT_EN to bound the WAIT state to
// TIMEOUT cycles. A timed-out job answers with p=0 and err=1. Without the
// macro WAIT waits indefinitely and err is tied to 0.
//
// Ports:
//   clk             system clock, all state on the rising edge
//   rst             asynchronous active-low reset
//   req0, req1      request levels from requester 0 / 1
//   a0, b0, a1, b1  operands, stable while the matching req is high
//   gnt0, gnt1      one-cycle grant pulse (operands already captured)
//   done0, done1    one-cycle completion pulse to the owner
//   p               product, valid with doneN, held until the next response
//   err             timeout flag, valid with doneN
//   mul_a, mul_b    registered operands to the multiplier
//   mul_start       one-cycle start pulse to the multiplier controller
//   mul_done        multiplier finished
//   mul_p           multiplier result, valid when mul_done=1
// -----------------------------------------------------------------------------
module mult_arbiter #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               done0,
  output logic               done1,
  output logic [2*WIDTH-1:0] p,
  output logic               err,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic               mul_start,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_p
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_last;
  logic               r_owner;
  logic [2*WIDTH-1:0] r_p;
  logic [WIDTH-1:0]   r_mul_a;
  logic [WIDTH-1:0]   r_mul_b;
  logic               w_any_req;
  logic               w_winner;
  logic               w_timeout;

  assign w_any_req = req0 | req1;
  // On a tie the requester that was not served last wins.
  assign w_winner  = (req0 & req1) ? ~r_last : req1;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // The counter reads TIMEOUT-1 on the edge that ends the TIMEOUT-th WAIT
  // cycle, i.e. the edge on which it would reach TIMEOUT.
  assign w_timeout = (r_state == S_WAIT) && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (r_state == S_START) begin
      r_cnt <= '0;                       // cleared on the WAIT entry edge
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign err = r_err;
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign w_unused_timeout = ^TIMEOUT;
  assign err              = 1'b0;
`endif

  // NOTE: every variable driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_next = S_START;
      S_START: w_state_next = S_WAIT;
      S_WAIT:  if (mul_done || w_timeout) w_state_next = S_RESP;
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;                   // requester 0 wins the first tie
      r_owner <= 1'b0;
      r_p     <= '0;
      r_mul_a <= '0;
      r_mul_b <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner <= w_winner;
            r_mul_a <= w_winner ? a1 : a0;
            r_mul_b <= w_winner ? b1 : b0;
          end
        end
        S_WAIT: begin
          // A done on the timeout edge still delivers the real result.
          if (mul_done) begin
            r_p   <= mul_p;
`ifdef MULT_ARB_TIMEOUT_EN
            r_err <= 1'b0;
          end else if (w_timeout) begin
            r_p   <= '0;
            r_err <= 1'b1;
`endif
          end
        end
        S_RESP:  r_last <= r_owner;
        default: ;
      endcase
    end
  end

  // Moore outputs: decoded from registered state only.
  assign mul_start = (r_state == S_START);
  assign gnt0      = mul_start & ~r_owner;
  assign gnt1      = mul_start &  r_owner;
  assign done0     = (r_state == S_RESP) & ~r_owner;
  assign done1     = (r_state == S_RESP) &  r_owner;
  assign p         = r_p;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;

endmodule

// File: tb/tb_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_arbiter
//
// Self-checking bench for mult_arbiter. A behavioural multiplier answers each
// start after a chosen latency. A job-level reference model (queue of jobs in
// flight, round-robin "last served" bit, held product) predicts every grant,
// completion cycle, owner, product and err flag. Directed scenarios are
// followed by a randomized request phase with spurious mul_done pulses.
// Build with +define+MULT_ARB_TIMEOUT_EN to include timeout scenarios.
// -----------------------------------------------------------------------------
module tb_mult_arbiter;

  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int PW      = 2 * WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0 = 1'b0, req1 = 1'b0;
  logic [WIDTH-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic             mul_done = 1'b0;
  logic [PW-1:0]    mul_p = '0;
  logic             gnt0, gnt1, done0, done1, err, mul_start;
  logic [PW-1:0]    p;
  logic [WIDTH-1:0] mul_a, mul_b;

  mult_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .a0        (a0),
    .b0        (b0),
    .a1        (a1),
    .b1        (b1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .done0     (done0),
    .done1     (done1),
    .p         (p),
    .err       (err),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_start (mul_start),
    .mul_done  (mul_done),
    .mul_p     (mul_p)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit owner;
    int prod;
    bit err;
    int done_cyc;
  } job_t;

  typedef struct {
    bit owner;
    int p;
    bit err;
  } resp_t;

  job_t  q[$];        // jobs granted and not yet answered
  resp_t d_log[$];    // observed responses
  bit    g_log[$];    // observed grant owners

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  bit m_last      = 1'b1;
  int m_p         = 0;
  bit m_idle_prev = 1'b1;

  logic             s_req0, s_req1;
  logic [WIDTH-1:0] s_a0, s_b0, s_a1, s_b1;

  int force_lat   = -1;
  bit spurious_en = 1'b0;
  bit mul_pend    = 1'b0;
  int mul_cnt     = 0;
  int mul_res     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int pick_lat();
    if (force_lat >= 0) return force_lat;
`ifdef MULT_ARB_TIMEOUT_EN
    begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) return 0;
      if (r == 1) return int'($urandom_range(16, 18));
    end
`endif
    return int'($urandom_range(1, 6));
  endfunction

  // Inputs as the DUT sees them on each rising edge.
  always @(posedge clk) begin
    s_req0 = req0;
    s_req1 = req1;
    s_a0   = a0;
    s_b0   = b0;
    s_a1   = a1;
    s_b1   = b1;
  end

  // Reference model, checker and multiplier model, all on the falling edge.
  always @(negedge clk) begin
    bit    g, exp_g, exp_w, exp_d;
    int    lat, ea, eb;
    job_t  j;
    resp_t r;
    cyc++;
    if (!rst) begin
      check("rst_outputs", {gnt0, gnt1, done0, done1, mul_start, err, p, mul_a, mul_b}, 0);
      q.delete();
      m_last      = 1'b1;
      m_p         = 0;
      m_idle_prev = 1'b1;
      mul_pend    = 1'b0;
      mul_done    = 1'b0;
    end else begin
      // multiplier model: one-cycle done pulse after the chosen latency
      if (mul_done) mul_done = 1'b0;
      if (mul_pend) begin
        if (mul_cnt == 1) begin
          mul_done = 1'b1;
          mul_p    = PW'(mul_res);
          mul_pend = 1'b0;
        end else begin
          mul_cnt--;
        end
      end

      g     = gnt0 | gnt1;
      exp_g = m_idle_prev && (s_req0 || s_req1);
      check("gnt_timing", g, exp_g);
      check("start_is_gnt", mul_start, g);
      check("gnt_onehot", gnt0 & gnt1, 0);
      if (g) begin
        exp_w = (s_req0 && s_req1) ? !m_last : s_req1;
        if (exp_g) check("winner", gnt1, exp_w);
        ea = gnt1 ? int'(s_a1) : int'(s_a0);
        eb = gnt1 ? int'(s_b1) : int'(s_b0);
        check("mul_a", mul_a, ea);
        check("mul_b", mul_b, eb);
        lat     = pick_lat();
        j.owner = gnt1;
`ifdef MULT_ARB_TIMEOUT_EN
        if (lat == 0 || lat > TIMEOUT) begin
          j.prod     = 0;
          j.err      = 1'b1;
          j.done_cyc = cyc + TIMEOUT + 1;
        end else
`endif
        begin
          j.prod     = ea * eb;
          j.err      = 1'b0;
          j.done_cyc = cyc + lat + 1;
        end
        q.push_back(j);
        g_log.push_back(gnt1);
        mul_pend = (lat > 0);
        mul_cnt  = lat;
        mul_res  = int'(mul_a) * int'(mul_b);
      end

      m_idle_prev = (q.size() == 0);

      exp_d = (q.size() > 0) && (q[0].done_cyc == cyc);
      check("done_timing", done0 | done1, exp_d);
      if (exp_d) begin
        check("done_owner", {done1, done0}, q[0].owner ? 2 : 1);
        check("product", p, q[0].prod);
        check("err", err, q[0].err);
        m_p     = q[0].prod;
        m_last  = q[0].owner;
        r.owner = q[0].owner;
        r.p     = int'(p);
        r.err   = err;
        d_log.push_back(r);
        void'(q.pop_front());
      end else begin
        check("p_hold", p, m_p);
      end

      // stray done with garbage data while no job is in flight
      if (spurious_en && !mul_pend && !mul_done && q.size() == 0 &&
          $urandom_range(0, 7) == 0) begin
        mul_done = 1'b1;
        mul_p    = PW'($urandom);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_gnt(input bit which, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if ((which ? gnt1 : gnt0) == 1'b1) break;
    end
    check("gnt_wait", which ? gnt1 : gnt0, 1);
  endtask

  task automatic wait_idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (q.size() == 0) break;
    end
    check("idle_wait", q.size(), 0);
  endtask

  task automatic clear_logs();
    g_log.delete();
    d_log.delete();
  endtask

  initial begin
    // reset
    #1 rst = 1'b0;
    #1 check("rst_async", {gnt0, gnt1, done0, done1, mul_start, err, p, mul_a, mul_b}, 0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    repeat (4) step();
    check("idle_no_start", mul_start, 0);

    // tie and fairness: both held high
    clear_logs();
    force_lat = 2;
    a0 = 4'd3;  b0 = 4'd5;
    a1 = 4'd15; b1 = 4'd15;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (g_log.size() >= 3) break;
    end
    req0 = 1'b0; req1 = 1'b0;
    wait_idle(100);
    check("tie_grants", g_log.size(), 3);
    check("tie_resps", d_log.size(), 3);
    if (g_log.size() >= 3) begin
      check("tie_order0", g_log[0], 0);
      check("tie_order1", g_log[1], 1);
      check("tie_order2", g_log[2], 0);
    end
    if (d_log.size() >= 2) begin
      check("tie_p0", d_log[0].p, 15);
      check("tie_p1", d_log[1].p, 225);
    end

    // single request
    clear_logs();
    force_lat = 5;
    a0 = 4'd7; b0 = 4'd9; req0 = 1'b1;
    wait_gnt(1'b0, 20);
    check("single_mul_a", mul_a, 7);
    check("single_mul_b", mul_b, 9);
    req0 = 1'b0;
    wait_idle(50);
    check("single_resps", d_log.size(), 1);
    check("single_grants", g_log.size(), 1);
    if (d_log.size() == 1) begin
      check("single_owner", d_log[0].owner, 0);
      check("single_p", d_log[0].p, 63);
    end
    if (g_log.size() == 1) check("single_gnt_owner", g_log[0], 0);

    // operand change after capture
    clear_logs();
    force_lat = 3;
    a0 = 4'd2; b0 = 4'd3; req0 = 1'b1;
    wait_gnt(1'b0, 20);
    a0 = 4'd6; req0 = 1'b0;
    wait_idle(50);
    check("stable_resps", d_log.size(), 1);
    if (d_log.size() == 1) check("stable_p", d_log[0].p, 6);

    // reset in the middle of a job
    clear_logs();
    force_lat = 6;
    a0 = 4'd5; b0 = 4'd5; req0 = 1'b1;
    wait_gnt(1'b0, 20);
    req0 = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1 check("rst_mid_async", {gnt0, gnt1, done0, done1, mul_start, err, p, mul_a, mul_b}, 0);
    step();
    step();
    rst = 1'b1;
    repeat (10) step();
    check("rst_mid_no_done", d_log.size(), 0);
    check("rst_mid_p", p, 0);
    force_lat = 1;
    a0 = 4'd3; b0 = 4'd4; req0 = 1'b1;
    wait_gnt(1'b0, 20);
    req0 = 1'b0;
    wait_idle(50);
    check("after_rst_resps", d_log.size(), 1);
    if (d_log.size() == 1) check("after_rst_p", d_log[0].p, 12);

`ifdef MULT_ARB_TIMEOUT_EN
    // multiplier never answers, req1 waiting behind
    clear_logs();
    force_lat = 0;
    a0 = 4'd5; b0 = 4'd6; req0 = 1'b1;
    wait_gnt(1'b0, 20);
    req0 = 1'b0;
    force_lat = 3;
    a1 = 4'd2; b1 = 4'd7; req1 = 1'b1;
    wait_gnt(1'b1, 60);
    req1 = 1'b0;
    wait_idle(50);
    check("to_resps", d_log.size(), 2);
    if (d_log.size() == 2) begin
      check("to_owner0", d_log[0].owner, 0);
      check("to_p0", d_log[0].p, 0);
      check("to_err0", d_log[0].err, 1);
      check("to_owner1", d_log[1].owner, 1);
      check("to_p1", d_log[1].p, 14);
      check("to_err1", d_log[1].err, 0);
    end
`endif

    // randomized traffic
    force_lat   = -1;
    spurious_en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      step();
      if (req0) begin
        if (gnt0 && $urandom_range(0, 1) == 1) begin
          req0 = 1'b0; a0 = WIDTH'($urandom); b0 = WIDTH'($urandom);
        end
      end else if ($urandom_range(0, 3) == 0) begin
        req0 = 1'b1; a0 = WIDTH'($urandom); b0 = WIDTH'($urandom);
      end
      if (req1) begin
        if (gnt1 && $urandom_range(0, 1) == 1) begin
          req1 = 1'b0; a1 = WIDTH'($urandom); b1 = WIDTH'($urandom);
        end
      end else if ($urandom_range(0, 3) == 0) begin
        req1 = 1'b1; a1 = WIDTH'($urandom); b1 = WIDTH'($urandom);
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    wait_idle(200);
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
